heater_checker: RTL and testbench

- Receive end of the heater data path: checks the PRBS word stream emerging from the heater's SRL/BRAM/DSP/pipeline chain.
- Self-synchronises a local LFSR to the incoming stream and flags any corrupted word with a sticky error.
- Maintains a saturating mismatch counter.
- Sits at the chain tail; drives the heater's error output and a lock indication.

---
 rtl/heater_checker.sv | 123 ++++++++++++
 tb/tb_heater_checker.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/heater_checker.sv
// PRBS checker at the tail of the heater chain: self-synchronises a local LFSR to the
// incoming word stream, reports lock, and flags mismatches with a sticky error and counter.
module heater_checker #(
    parameter int unsigned W          = 32,
    parameter int unsigned SYNC_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 8,
    parameter int unsigned CW         = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          err_clear,
    input  logic          din_valid,
    input  logic [W-1:0]  din,
    output logic          locked,
    output logic          error,
    output logic [CW-1:0] err_count
);

    localparam int unsigned MW = $clog2(SYNC_COUNT + 1);
    localparam int unsigned LW = $clog2(LOSS_COUNT + 1);

    typedef enum logic [1:0] {StIdle, StSync, StLocked} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    expected_q, expected_d;
    logic [MW-1:0]   match_cnt_q, match_cnt_d;
    logic [LW-1:0]   miss_cnt_q, miss_cnt_d;
    logic            error_q, error_d;
    logic [CW-1:0]   err_count_q, err_count_d;
    logic            hit;
    logic            din_zero;

    // x^32 + x^22 + x^2 + x + 1, shifting left with feedback into bit 0
    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] v);
        return {v[W-2:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    assign hit      = (din == expected_q);
    assign din_zero = (din == '0);

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        error_d     = error_q;
        err_count_d = err_count_q;

        if (!enable) begin
            state_d     = StIdle;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StSync;
                StSync: begin
                    if (din_valid) begin
                        // An all-zero word is the LFSR lock-up state, so it never counts as a match
                        if (!din_zero && hit) begin
                            match_cnt_d = match_cnt_q + MW'(1);
                        end else begin
                            match_cnt_d = '0;
                        end
                        expected_d = din_zero ? '0 : lfsr_next(din);
                        if (match_cnt_d == MW'(SYNC_COUNT)) begin
                            state_d    = StLocked;
                            miss_cnt_d = '0;
                        end
                    end
                end
                StLocked: begin
                    if (din_valid) begin
                        expected_d = lfsr_next(expected_q);
                        if (hit) begin
                            miss_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + LW'(1);
                            error_d    = 1'b1;
                            if (err_count_q != '1) begin
                                err_count_d = err_count_q + CW'(1);
                            end
                            if (miss_cnt_d == LW'(LOSS_COUNT)) begin
                                state_d     = StSync;
                                match_cnt_d = '0;
                                expected_d  = lfsr_next(din);
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (err_clear) begin
            error_d     = 1'b0;
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            expected_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            error_q     <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            error_q     <= error_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = (state_q == StLocked);
    assign error     = error_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_heater_checker.sv
// Randomised and directed bench for heater_checker, checked every cycle against a
// behavioural model built from the checker's word-level rules.
module tb_heater_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        err_clear;
    logic        din_valid;
    logic [31:0] din;
    logic        locked, error;
    logic [15:0] err_count;
    logic        locked4, error4;
    logic [3:0]  err_count4;

    int vectors = 0;
    int miscompares = 0;

    // model state
    int          m_mode;      // 0 idle, 1 sync, 2 locked
    logic [31:0] m_exp;
    int          m_match, m_miss;
    bit          m_err;
    int          m_cnt16, m_cnt4;
    logic [31:0] prbs;

    heater_checker dut (
        .clk(clk), .reset(reset), .enable(enable), .err_clear(err_clear),
        .din_valid(din_valid), .din(din), .locked(locked), .error(error),
        .err_count(err_count)
    );

    heater_checker #(.CW(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .err_clear(err_clear),
        .din_valid(din_valid), .din(din), .locked(locked4), .error(error4),
        .err_count(err_count4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] nxt(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_exp = '0; m_match = 0; m_miss = 0;
        m_err = 0; m_cnt16 = 0; m_cnt4 = 0;
    endtask

    task automatic model_step(input bit en, input bit clr, input bit v, input logic [31:0] d);
        bit mism;
        if (!en) begin
            m_mode = 0; m_match = 0; m_miss = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (v && m_mode == 1) begin
            if (d != 0 && d == m_exp) m_match++;
            else m_match = 0;
            m_exp = (d == 0) ? 32'h0 : nxt(d);
            if (m_match == 4) begin
                m_mode = 2; m_miss = 0;
            end
        end else if (v && m_mode == 2) begin
            mism = (d != m_exp);
            m_exp = nxt(m_exp);
            if (!mism) m_miss = 0;
            else begin
                m_miss++;
                m_err = 1;
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt4 < 15) m_cnt4++;
                if (m_miss == 8) begin
                    m_mode = 1; m_match = 0; m_exp = nxt(d);
                end
            end
        end
        if (clr) begin
            m_err = 0; m_cnt16 = 0; m_cnt4 = 0;
        end
    endtask

    // One clock of stimulus; the model advances with the DUT's edge.
    task automatic cycle(input bit en, input bit clr, input bit v, input logic [31:0] d);
        enable = en; err_clear = clr; din_valid = v; din = d;
        @(posedge clk);
        if (!reset) model_step(en, clr, v, d);
        #1;
    endtask

    task automatic clean(input bit clr = 0);
        cycle(1, clr, 1, prbs);
        prbs = nxt(prbs);
    endtask

    task automatic corrupt(input logic [31:0] mask, input bit clr = 0);
        cycle(1, clr, 1, prbs ^ mask);
        prbs = nxt(prbs);
    endtask

    always @(negedge clk) begin
        check("locked", {31'b0, locked}, {31'b0, m_mode == 2});
        check("error", {31'b0, error}, {31'b0, m_err});
        check("err_count", {16'b0, err_count}, m_cnt16);
        check("locked_cw4", {31'b0, locked4}, {31'b0, m_mode == 2});
        check("err_count_cw4", {28'b0, err_count4}, m_cnt4);
    end

    initial begin
        int r;
        reset = 1; enable = 0; err_clear = 0; din_valid = 0; din = '0;
        model_reset();
        repeat (5) @(posedge clk);
        #1 reset = 0;
        check("reset_err_count", {16'b0, err_count}, 0);

        // acquire lock from seed 1
        cycle(1, 0, 0, '0);
        prbs = 32'h1;
        repeat (4) clean();
        check("not_locked_after_4", {31'b0, locked}, 0);
        clean();
        check("locked_after_5", {31'b0, locked}, 1);
        repeat (1000) clean();
        check("clean_err_count", {16'b0, err_count}, 0);
        check("clean_error", {31'b0, error}, 0);

        // single bit flip
        corrupt(32'h1);
        check("flip_error", {31'b0, error}, 1);
        check("flip_count", {16'b0, err_count}, 1);
        check("flip_locked", {31'b0, locked}, 1);
        repeat (20) clean();
        check("flip_no_more", {16'b0, err_count}, 1);

        // loss of lock after 8 bad words
        cycle(1, 1, 0, '0);
        repeat (8) begin
            cycle(1, 0, 1, 32'hDEADBEEF);
            prbs = nxt(prbs);
        end
        check("loss_count", {16'b0, err_count}, 8);
        check("loss_unlocked", {31'b0, locked}, 0);
        repeat (5) clean();
        check("relock", {31'b0, locked}, 1);
        check("relock_error_sticky", {31'b0, error}, 1);

        // err_clear held through a burst
        repeat (3) begin
            corrupt(32'h8000_0000, 1);
            check("clr_error", {31'b0, error}, 0);
            check("clr_count", {16'b0, err_count}, 0);
        end
        clean();
        corrupt(32'h10);
        check("after_clr_count", {16'b0, err_count}, 1);

        // zeros in SYNC never lock
        cycle(0, 0, 0, '0);
        cycle(1, 0, 0, '0);
        repeat (10) cycle(1, 0, 1, 32'h0);
        check("zeros_no_lock", {31'b0, locked}, 0);
        repeat (5) clean();
        check("zeros_then_lock", {31'b0, locked}, 1);

        // saturation of the 4-bit counter
        repeat (20) begin
            corrupt(32'h4);
            clean();
        end
        check("sat_cw4", {28'b0, err_count4}, 15);
        check("sat_cw16", {16'b0, err_count}, 21);

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            bit en, clr, v;
            en  = ($urandom_range(0, 99) >= 2);
            clr = ($urandom_range(0, 99) < 3);
            v   = ($urandom_range(0, 99) < 75);
            r   = $urandom_range(0, 99);
            if (!v) cycle(en, clr, 0, $urandom);
            else if (r < 85) begin cycle(en, clr, 1, prbs); prbs = nxt(prbs); end
            else if (r < 92) begin
                cycle(en, clr, 1, prbs ^ (32'h1 << $urandom_range(0, 31)));
                prbs = nxt(prbs);
            end
            else if (r < 96) begin cycle(en, clr, 1, $urandom); prbs = nxt(prbs); end
            else cycle(en, clr, 1, 32'h0);
        end

        // async reset mid-cycle while locked with errors
        cycle(1, 0, 0, '0);
        repeat (6) clean();
        corrupt(32'h2);
        #2 reset = 1;
        model_reset();
        #1;
        check("async_locked", {31'b0, locked}, 0);
        check("async_error", {31'b0, error}, 0);
        check("async_count", {16'b0, err_count}, 0);
        check("async_count_cw4", {28'b0, err_count4}, 0);
        repeat (2) cycle(1, 0, 1, prbs);
        reset = 0;
        cycle(1, 0, 0, '0);
        repeat (5) clean();
        check("post_reset_lock", {31'b0, locked}, 1);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
